// File: rtl/pipeline_controller_pkg.sv
// Shared types and defaults for the pipeline run/step/halt sequencer.
// The enum values are also the o_state debug readout.
package pipeline_controller_pkg;

    localparam int NB_STATE                = 3;
    localparam int NB_CMD                  = 2;
    localparam int N_DRAIN_CYCLES_DEFAULT  = 3;
    localparam int NB_DRAIN_CNT_DEFAULT    = 2;
    localparam int NB_CYCLE_COUNT_DEFAULT  = 32;

    typedef enum logic [NB_STATE-1:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    typedef enum logic [NB_CMD-1:0] {
        CMD_NOP   = 2'b00,
        CMD_RUN   = 2'b01,
        CMD_STEP  = 2'b10,
        CMD_PAUSE = 2'b11
    } cmd_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic pipe_en;
    } pipe_ctrl_t;

endpackage

// File: rtl/pipeline_controller_if.sv
// Debug command channel into the pipeline sequencer.
// A command transfers on a clock edge where cmd_valid and cmd_ready are both high;
// cmd_ready never depends on cmd_valid, and an unaccepted command may be withdrawn.
interface pipeline_controller_if
    import pipeline_controller_pkg::*;
();
    logic              cmd_valid;
    logic [NB_CMD-1:0] cmd;
    logic              cmd_ready;

    modport master (output cmd_valid, output cmd, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd, output cmd_ready);
endinterface

// File: rtl/pipeline_controller_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int NB = 32
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_en,
    output logic [NB-1:0] o_count
);
    logic [NB-1:0] count_q;
    logic [NB-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_en && (count_q != {NB{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;
endmodule

// File: rtl/pipeline_controller.sv
// Run/step/halt sequencer for the 5-stage pipeline: decodes debug commands, merges the
// load-use stall, detects HALT at ID and drains EX/MA/WB before freezing the core.
module pipeline_controller
    import pipeline_controller_pkg::*;
#(
    parameter int N_DRAIN_CYCLES = N_DRAIN_CYCLES_DEFAULT,
    parameter int NB_DRAIN_CNT   = NB_DRAIN_CNT_DEFAULT,
    parameter int NB_CYCLE_COUNT = NB_CYCLE_COUNT_DEFAULT
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    pipeline_controller_if.slave      cmd_bus,
    input  logic                      i_id_stall,
    input  logic                      i_id_halt,
    output logic                      o_pc_en,
    output logic                      o_if_id_en,
    output logic                      o_if_id_flush,
    output logic                      o_pipe_en,
    output logic [NB_STATE-1:0]       o_state,
    output logic                      o_halted,
    output logic                      o_step_done,
    output logic [NB_CYCLE_COUNT-1:0] o_cycle_count
);
    localparam logic [NB_DRAIN_CNT-1:0] DRAIN_LOAD = NB_DRAIN_CNT'(N_DRAIN_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [NB_DRAIN_CNT-1:0] cnt_q, cnt_d;
    logic                    halted_q, halted_d;
    logic                    step_done_q, step_done_d;
    pipe_ctrl_t              ctrl;
    logic                    cmd_ready;
    logic                    cmd_fire;
    logic                    halt_take;
    cmd_t                    cmd;

    assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign cmd_fire  = cmd_bus.cmd_valid && cmd_ready;
    assign cmd       = cmd_t'(cmd_bus.cmd);
    // A HALT sitting behind a load-use stall is only taken once the stall clears.
    assign halt_take = i_id_halt && !i_id_stall;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        step_done_d = 1'b0;
        ctrl        = '0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire && (cmd == CMD_RUN)) begin
                    state_d = ST_RUN;
                end else if (cmd_fire && (cmd == CMD_STEP)) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN, ST_STEP: begin
                ctrl.pipe_en  = 1'b1;
                ctrl.pc_en    = !i_id_stall;
                ctrl.if_id_en = !i_id_stall;
                if (halt_take) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end else if (state_q == ST_STEP) begin
                    state_d     = ST_IDLE;
                    step_done_d = 1'b1;
                end else if (cmd_fire && (cmd == CMD_PAUSE)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Keep bubbling IF/ID so nothing behind HALT enters the back end.
                ctrl.pipe_en     = 1'b1;
                ctrl.if_id_en    = 1'b1;
                ctrl.if_id_flush = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_HALTED;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        halted_d = (state_d == ST_HALTED);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            halted_q    <= 1'b0;
            step_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            halted_q    <= halted_d;
            step_done_q <= step_done_d;
        end
    end

    sat_counter #(
        .NB (NB_CYCLE_COUNT)
    ) u_cycle_counter (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (ctrl.pipe_en),
        .o_count (o_cycle_count)
    );

    assign cmd_bus.cmd_ready = cmd_ready;
    assign o_pc_en           = ctrl.pc_en;
    assign o_if_id_en        = ctrl.if_id_en;
    assign o_if_id_flush     = ctrl.if_id_flush;
    assign o_pipe_en         = ctrl.pipe_en;
    assign o_state           = state_q;
    assign o_halted          = halted_q;
    assign o_step_done       = step_done_q;
endmodule

// File: tb/tb_pipeline_controller.sv
// Bench for pipeline_controller: directed command/stall/halt sequences, a behavioural
// model checked every cycle, and literal checkpoints along the way.
module tb_pipeline_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, stall, halt;

    pipeline_controller_if bus  ();
    pipeline_controller_if bus4 ();
    assign bus4.cmd_valid = bus.cmd_valid;
    assign bus4.cmd       = bus.cmd;

    logic        pc_en, if_id_en, if_id_flush, pipe_en, halted, step_done;
    logic [2:0]  state;
    logic [31:0] count;
    logic        s_pc_en, s_if_id_en, s_if_id_flush, s_pipe_en, s_halted, s_step_done;
    logic [2:0]  s_state;
    logic [3:0]  s_count;

    pipeline_controller dut (
        .i_clk(clk), .i_reset(rst), .cmd_bus(bus),
        .i_id_stall(stall), .i_id_halt(halt),
        .o_pc_en(pc_en), .o_if_id_en(if_id_en), .o_if_id_flush(if_id_flush),
        .o_pipe_en(pipe_en), .o_state(state), .o_halted(halted),
        .o_step_done(step_done), .o_cycle_count(count)
    );

    pipeline_controller #(.NB_CYCLE_COUNT(4)) dut_sat (
        .i_clk(clk), .i_reset(rst), .cmd_bus(bus4),
        .i_id_stall(stall), .i_id_halt(halt),
        .o_pc_en(s_pc_en), .o_if_id_en(s_if_id_en), .o_if_id_flush(s_if_id_flush),
        .o_pipe_en(s_pipe_en), .o_state(s_state), .o_halted(s_halted),
        .o_step_done(s_step_done), .o_cycle_count(s_count)
    );

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: mode numbers are the documented o_state values.
    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_DRAIN = 3, M_HALTED = 4;
    int m_mode = M_IDLE;
    int m_drain_left = 0;
    int m_count = 0;
    bit m_halted = 0;
    bit m_step_done = 0;
    bit model_valid = 0;

    always @(negedge clk) begin
        logic       e_pc, e_if, e_flush, e_pipe, e_ready;
        logic [9:0] exp_w;
        bit         executing;
        executing = (m_mode == M_RUN) || (m_mode == M_STEP);
        if (model_valid) begin
            e_pipe  = executing || (m_mode == M_DRAIN);
            e_pc    = executing && !stall;
            e_if    = (executing && !stall) || (m_mode == M_DRAIN);
            e_flush = (m_mode == M_DRAIN);
            e_ready = (m_mode == M_IDLE) || (m_mode == M_RUN);
            exp_q.push_back({e_pc, e_if, e_flush, e_pipe, e_ready, m_halted, m_step_done, 3'(m_mode)});
            exp_w = exp_q.pop_front();
            check("pc_en",       pc_en,         exp_w[9]);
            check("if_id_en",    if_id_en,      exp_w[8]);
            check("if_id_flush", if_id_flush,   exp_w[7]);
            check("pipe_en",     pipe_en,       exp_w[6]);
            check("cmd_ready",   bus.cmd_ready, exp_w[5]);
            check("halted",      halted,        exp_w[4]);
            check("step_done",   step_done,     exp_w[3]);
            check("state",       state,         exp_w[2:0]);
            check("cycle_count", count,         m_count);
            check("sat_state",   s_state,       exp_w[2:0]);
            check("sat_pc_en",   s_pc_en,       exp_w[9]);
            check("sat_count",   s_count,       (m_count > 15) ? 15 : m_count);
        end
        if (rst) begin
            m_mode = M_IDLE; m_drain_left = 0; m_count = 0;
            m_halted = 0; m_step_done = 0; model_valid = 1;
        end else if (model_valid) begin
            if (executing || m_mode == M_DRAIN) m_count++;
            m_step_done = 0;
            case (m_mode)
                M_IDLE: begin
                    if (bus.cmd_valid && bus.cmd == 2'b01) m_mode = M_RUN;
                    else if (bus.cmd_valid && bus.cmd == 2'b10) m_mode = M_STEP;
                end
                M_RUN, M_STEP: begin
                    if (halt && !stall) begin
                        m_mode = M_DRAIN; m_drain_left = 3;
                    end else if (m_mode == M_STEP) begin
                        m_mode = M_IDLE; m_step_done = 1;
                    end else if (bus.cmd_valid && bus.cmd == 2'b11) begin
                        m_mode = M_IDLE;
                    end
                end
                M_DRAIN: begin
                    m_drain_left--;
                    if (m_drain_left == 0) m_mode = M_HALTED;
                end
                default: ;
            endcase
            m_halted = (m_mode == M_HALTED);
        end
    end

    task automatic apply(input logic r, input logic v, input logic [1:0] c,
                         input logic s, input logic h);
        rst = r; bus.cmd_valid = v; bus.cmd = c; stall = s; halt = h;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset for two cycles, one carrying a RUN that must be ignored.
        apply(1, 0, 2'b00, 0, 0); tick();
        apply(1, 1, 2'b01, 0, 0); tick();
        check("rst_state", state, 0);
        check("rst_count", count, 0);
        check("rst_ready", bus.cmd_ready, 1);
        check("rst_pipe_en", pipe_en, 0);
        check("rst_halted", halted, 0);

        // RUN for 10 unstalled cycles.
        apply(0, 1, 2'b01, 0, 0); tick();
        check("run_state", state, 1);
        for (int i = 0; i < 10; i++) begin
            apply(0, 0, 2'b00, 0, 0);
            check("run_pc_en", pc_en, 1);
            tick();
        end
        check("run_count10", count, 10);

        // One stalled cycle, then PAUSE.
        apply(0, 0, 2'b00, 1, 0);
        check("stall_pc_en", pc_en, 0);
        check("stall_if_id_en", if_id_en, 0);
        check("stall_pipe_en", pipe_en, 1);
        tick();
        apply(0, 1, 2'b11, 0, 0); tick();
        check("pause_state", state, 0);
        check("pause_count", count, 12);

        // Three single steps from IDLE.
        for (int k = 0; k < 3; k++) begin
            apply(0, 1, 2'b10, 0, 0); tick();
            apply(0, 0, 2'b00, 0, 0);
            check("step_pc_en", pc_en, 1);
            check("step_state", state, 2);
            tick();
            check("step_done_hi", step_done, 1);
            check("step_back_idle", state, 0);
            apply(0, 0, 2'b00, 0, 0); tick();
            check("step_done_lo", step_done, 0);
        end
        check("step_count", count, 15);

        // HALT held behind a stall, then drain and freeze.
        apply(0, 1, 2'b01, 0, 0); tick();
        apply(0, 0, 2'b00, 1, 1);
        check("halt_stall_pc_en", pc_en, 0);
        tick();
        check("halt_deferred", state, 1);
        apply(0, 0, 2'b00, 0, 1); tick();
        check("drain_entered", state, 3);
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 2'b00, 0, 0);
            check("drain_flush", if_id_flush, 1);
            check("drain_pc_en", pc_en, 0);
            check("drain_if_id_en", if_id_en, 1);
            tick();
        end
        check("halted_state", state, 4);
        check("halted_flag", halted, 1);
        check("halt_count", count, 20);
        apply(0, 1, 2'b01, 0, 0);
        check("halted_ready", bus.cmd_ready, 0);
        tick();
        apply(0, 0, 2'b00, 0, 0); tick(); tick();
        check("halted_ignores_run", state, 4);

        // HALT and PAUSE together, then reset mid-drain.
        apply(1, 0, 2'b00, 0, 0); tick();
        apply(0, 1, 2'b01, 0, 0); tick();
        apply(0, 1, 2'b11, 0, 1); tick();
        check("halt_beats_pause", state, 3);
        apply(0, 0, 2'b00, 0, 0); tick();
        apply(1, 0, 2'b00, 0, 0); tick();
        check("drain_rst_state", state, 0);
        check("drain_rst_count", count, 0);
        check("drain_rst_pipe_en", pipe_en, 0);
        check("drain_rst_flush", if_id_flush, 0);
        check("drain_rst_halted", halted, 0);

        // 20 running cycles: the 4-bit counter must stick at 15.
        apply(0, 1, 2'b01, 0, 0); tick();
        for (int i = 0; i < 20; i++) begin
            apply(0, 0, 2'b00, 0, 0); tick();
        end
        check("sat_hold15", s_count, 15);
        check("wide_count20", count, 20);
        apply(0, 1, 2'b11, 0, 0); tick();
        apply(0, 0, 2'b00, 0, 0); tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
